// File: rtl/regfile_param_sweep_if.sv
// Bus interface for regfile_param_sweep: the write port, packed read ports,
// the clear request and the status flags. The master drives the inputs and
// the slave (the register file) drives the outputs.
interface regfile_param_sweep_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                     i_reg_write;
   logic [ADDR_W-1:0]        i_write_reg_no;
   logic [DATA_W-1:0]        i_write_data;
   logic [NUM_RD*ADDR_W-1:0] i_read_reg;
   logic [NUM_RD*DATA_W-1:0] o_read_data;
   logic                     i_clear_req;
   logic                     o_busy;
   logic                     o_clear_done;
   logic                     o_write_drop;

   modport master (
      output i_reg_write, i_write_reg_no, i_write_data, i_read_reg, i_clear_req,
      input  o_read_data, o_busy, o_clear_done, o_write_drop
   );

   modport slave (
      input  i_reg_write, i_write_reg_no, i_write_data, i_read_reg, i_clear_req,
      output o_read_data, o_busy, o_clear_done, o_write_drop
   );
endinterface

// File: rtl/regfile_param_sweep.sv
// Parametrised multi-read-port register file for the single-cycle MIPS
// datapath. Optional hardwired-zero entry 0 and write-to-read bypass, plus a
// clear engine that zeroes one entry per cycle while reporting Busy, and pulses
// ClearDone once the last entry has been swept.
module regfile_param_sweep #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   regfile_param_sweep_if.slave  bus
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   w_ptr_nxt;
   logic                r_clear_done;
   logic                w_clear_done_nxt;
   logic                r_write_drop;
   logic                w_busy;
   logic                w_wr_en;
   logic [DATA_W-1:0]   r_mem [NUM_REGS];
   logic [DATA_W-1:0]   w_rd_port [NUM_RD];
   logic [NUM_RD*DATA_W-1:0] w_read_data;

   // Busy comes straight from the state register, so it has no input-to-output path.
   assign w_busy = (r_state == S_CLEAR);

   // A write lands only when the sweep is idle and it does not target a hardwired zero.
   assign w_wr_en = bus.i_reg_write && !w_busy &&
                    !((ZERO_REG != 0) && (bus.i_write_reg_no == '0));

   // Next-state logic for the clear sweep.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_state_nxt      = r_state;
      w_ptr_nxt        = r_ptr;
      w_clear_done_nxt = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.i_clear_req) begin
               w_state_nxt = S_CLEAR;
               w_ptr_nxt   = '0;
            end
         end
         S_CLEAR: begin
            // Incrementing from the last entry wraps to 0 on the same edge that leaves CLEAR.
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr == ADDR_W'(NUM_REGS - 1)) begin
               w_state_nxt      = S_IDLE;
               w_clear_done_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, pointer and status flag registers; reset aborts any sweep in progress.
   always_ff @(posedge i_clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_clear_done <= 1'b0;
         r_write_drop <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ptr        <= w_ptr_nxt;
         r_clear_done <= w_clear_done_nxt;
         r_write_drop <= bus.i_reg_write && w_busy;
      end
   end

   // Storage array: reset, sweep clear, or normal write, in that priority.
   always_ff @(posedge i_clock) begin
      // NOTE: this array is reset on purpose -- the file must read all zeros after reset, which makes it flops rather than RAM.
      if (i_reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_busy) begin
         r_mem[r_ptr] <= '0;
      end else if (w_wr_en) begin
         r_mem[bus.i_write_reg_no] <= bus.i_write_data;
      end
   end

   // Per-port combinational read: zero register beats bypass, bypass beats stored value.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      assign w_addr = bus.i_read_reg[k*ADDR_W +: ADDR_W];
      assign w_rd_port[k] =
         ((ZERO_REG != 0) && (w_addr == '0))                          ? '0 :
         ((BYPASS != 0) && w_wr_en && (w_addr == bus.i_write_reg_no)) ? bus.i_write_data :
                                                                        r_mem[w_addr];
   end

   // Pack the per-port results onto the bus.
   always_comb begin
      w_read_data = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         w_read_data[k*DATA_W +: DATA_W] = w_rd_port[k];
      end
   end

   assign bus.o_read_data  = w_read_data;
   assign bus.o_busy       = w_busy;
   assign bus.o_clear_done = r_clear_done;
   assign bus.o_write_drop = r_write_drop;

endmodule

// File: tb/tb_regfile_param_sweep.sv
// Self-checking bench for regfile_param_sweep (32x32, two read ports, zero
// register and bypass enabled). A behavioural model tracks register contents
// and the sweep position as plain integers and is compared every cycle.
module tb_regfile_param_sweep;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int NREGS = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_param_sweep_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

   regfile_param_sweep #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
   ) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   // Stimulus
   logic          we;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;
   logic [AW-1:0] ra [NR];
   logic          creq;

   // Reference model: contents, and index of the next entry to sweep (-1 = idle)
   logic [DW-1:0] mem [NREGS];
   int            sweep_idx;
   logic          exp_done;
   logic          exp_drop;

   int total = 0;
   int bad   = 0;
   int busy_cnt;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      if (a == '0) return '0;
      if (we && (sweep_idx < 0) && (a == wa)) return wd;
      return mem[a];
   endfunction

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < NREGS; i++) mem[i] = '0;
         sweep_idx = -1;
         exp_done  = 1'b0;
         exp_drop  = 1'b0;
      end else begin
         exp_drop = we && (sweep_idx >= 0);
         exp_done = 1'b0;
         if (sweep_idx >= 0) begin
            mem[sweep_idx] = '0;
            sweep_idx++;
            if (sweep_idx == NREGS) begin
               sweep_idx = -1;
               exp_done  = 1'b1;
            end
         end else begin
            if (we && (wa != '0)) mem[wa] = wd;
            if (creq) sweep_idx = 0;
         end
      end
   endtask

   // One clock: drive inputs, check reads before the edge, check flags after it.
   task automatic step(input bit chk_rd = 1'b1);
      bus.i_reg_write    = we;
      bus.i_write_reg_no = wa;
      bus.i_write_data   = wd;
      bus.i_read_reg     = {ra[1], ra[0]};
      bus.i_clear_req    = creq;
      #1;
      if (chk_rd) begin
         for (int k = 0; k < NR; k++) begin
            check($sformatf("rd%0d[r%0d]", k, ra[k]), bus.o_read_data[k*DW +: DW], model_read(ra[k]));
         end
      end
      @(posedge clk);
      model_edge();
      #1;
      check("busy",       DW'(bus.o_busy),       DW'(sweep_idx >= 0));
      check("clear_done", DW'(bus.o_clear_done), DW'(exp_done));
      check("write_drop", DW'(bus.o_write_drop), DW'(exp_drop));
      if (bus.o_busy) busy_cnt++;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; we = 1'b0; wa = '0; wd = '0; creq = 1'b0;
   endtask

   task automatic read_all();
      idle_inputs();
      for (int a = 0; a < NREGS; a++) begin
         ra[0] = AW'(a);
         ra[1] = AW'(NREGS - 1 - a);
         step();
      end
   endtask

   initial begin
      idle_inputs();
      ra[0] = '0; ra[1] = '0;
      for (int i = 0; i < NREGS; i++) mem[i] = '0;
      sweep_idx = -1; exp_done = 1'b0; exp_drop = 1'b0; busy_cnt = 0;

      // Reset: contents undefined beforehand, so reads are not compared yet
      rst = 1'b1;
      step(1'b0);
      step();
      read_all();

      // r7 write then read on both ports; write to r0 is discarded silently
      we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; step();
      we = 1'b0; ra[0] = 5'd7; ra[1] = 5'd7; step();
      check("r7_port1", bus.o_read_data[DW +: DW], 32'hDEADBEEF);
      we = 1'b1; wa = 5'd0; wd = 32'h1234; ra[0] = 5'd0; step();
      we = 1'b0; step();

      // Same-cycle bypass of r9 onto port 0
      we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5; ra[0] = 5'd9; ra[1] = 5'd7; #1;
      bus.i_reg_write = we; bus.i_write_reg_no = wa; bus.i_write_data = wd;
      bus.i_read_reg = {ra[1], ra[0]}; #1;
      check("bypass_r9", bus.o_read_data[DW-1:0], 32'hA5A5A5A5);
      step();
      we = 1'b0; step();

      // Fill r1..r31 with their index, then sweep; drop a write and re-pulse ClearReq mid-sweep
      for (int i = 1; i < NREGS; i++) begin
         we = 1'b1; wa = AW'(i); wd = DW'(i); step();
      end
      we = 1'b0; ra[0] = 5'd5; ra[1] = 5'd3;
      busy_cnt = 0;
      creq = 1'b1; step();
      creq = 1'b0;
      for (int i = 0; i < 40; i++) begin
         we   = (i == 2);
         wa   = 5'd3;
         wd   = 32'h55;
         creq = (i == 10);
         step();
      end
      check("busy_len", DW'(busy_cnt), DW'(NREGS));
      read_all();

      // Reset in the middle of a sweep while r20 still holds its value
      we = 1'b1; wa = 5'd20; wd = 32'h77; step();
      we = 1'b0; ra[0] = 5'd20; ra[1] = 5'd31;
      creq = 1'b1; step();
      creq = 1'b0;
      for (int i = 0; i < 9; i++) step();
      rst = 1'b1; step();
      rst = 1'b0; step();
      check("r20_after_rst", bus.o_read_data[DW-1:0], '0);
      for (int i = 0; i < 35; i++) step();

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         rst   = ($urandom_range(0, 199) == 0);
         we    = $urandom_range(0, 1) == 1;
         wa    = AW'($urandom_range(0, NREGS - 1));
         wd    = $urandom;
         creq  = ($urandom_range(0, 29) == 0);
         ra[0] = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREGS - 1));
         ra[1] = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREGS - 1));
         step();
      end
      for (int i = 0; i < 40; i++) begin
         idle_inputs();
         step();
      end
      read_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
